// File: rtl/cla_serial_add_ctrl.sv
// cla_serial_add_ctrl: byte-serial add/sub sequencer driving one shared external 8-bit CLA
module cla_serial_add_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             out_zero,
   output logic             busy,
   output logic [7:0]       cla_a,
   output logic [7:0]       cla_b,
   output logic             cla_cin,
   input  logic [7:0]       cla_sum,
   input  logic             cla_cout
);
   localparam int NBYTES = WIDTH / 8;
   localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] a_reg, b_reg, res, res_nx;
   logic carry_reg;
   logic [IW-1:0] idx;
   logic last;
   assign last = idx == LAST;
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   always_comb
      state_nx = (state == IDLE && in_valid)  ? RUN  :
                 (state == RUN  && last)      ? DONE :
                 (state == DONE && out_ready) ? IDLE : state;
   always_comb begin
      in_ready  = state == IDLE;
      out_valid = state == DONE;
      busy      = state != IDLE;
      cla_a     = state == RUN ? a_reg[8*idx +: 8] : 8'd0;
      cla_b     = state == RUN ? b_reg[8*idx +: 8] : 8'd0;
      cla_cin   = state == RUN ? carry_reg : 1'b0;
   end
   // result including the byte the CLA is producing this cycle
   always_comb begin
      res_nx = res;
      res_nx[8*idx +: 8] = cla_sum;
   end
   always_ff @(posedge clk)
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         res       <= '0;
         carry_reg <= 1'b0;
         idx       <= '0;
         out_sum   <= '0;
         out_carry <= 1'b0;
         out_ovf   <= 1'b0;
         out_zero  <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_reg     <= in_a;
         b_reg     <= in_sub ? ~in_b : in_b;
         carry_reg <= in_sub;
         idx       <= '0;
         res       <= '0;
      end else if (state == RUN) begin
         res       <= res_nx;
         carry_reg <= cla_cout;
         idx       <= idx + 1'b1;
         if (last) begin
            out_sum   <= res_nx;
            out_carry <= cla_cout;
            out_ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (cla_sum[7] != a_reg[WIDTH-1]);
            out_zero  <= res_nx == '0;
         end
      end
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// tb_cla_serial_add_ctrl: scoreboard bench for the serial CLA controller (WIDTH=32 and WIDTH=8)
module tb_cla_serial_add_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic in_valid = 1'b0, in_ready, in_sub = 1'b0, out_valid, out_ready = 1'b0;
   logic [31:0] in_a = '0, in_b = '0, out_sum;
   logic out_carry, out_ovf, out_zero, busy, cla_cin, cla_cout;
   logic [7:0] cla_a, cla_b, cla_sum;
   assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {8'd0, cla_cin};

   cla_serial_add_ctrl #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero), .busy(busy),
      .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin), .cla_sum(cla_sum), .cla_cout(cla_cout));

   logic w_in_valid = 1'b0, w_in_ready, w_in_sub = 1'b0, w_out_valid, w_out_ready = 1'b0;
   logic [7:0] w_in_a = '0, w_in_b = '0, w_out_sum;
   logic w_out_carry, w_out_ovf, w_out_zero, w_busy, w_cla_cin, w_cla_cout;
   logic [7:0] w_cla_a, w_cla_b, w_cla_sum;
   assign {w_cla_cout, w_cla_sum} = {1'b0, w_cla_a} + {1'b0, w_cla_b} + {8'd0, w_cla_cin};

   cla_serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
      .in_sub(w_in_sub), .out_valid(w_out_valid), .out_ready(w_out_ready), .out_sum(w_out_sum),
      .out_carry(w_out_carry), .out_ovf(w_out_ovf), .out_zero(w_out_zero), .busy(w_busy),
      .cla_a(w_cla_a), .cla_b(w_cla_b), .cla_cin(w_cla_cin), .cla_sum(w_cla_sum), .cla_cout(w_cla_cout));

   typedef struct packed {logic [31:0] sum; logic carry; logic ovf; logic zero;} exp_t;
   exp_t exp_q[$];
   int t_acc;
   int checks = 0, errors = 0;

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
      exp_t r;
      logic [31:0] eb;
      logic [32:0] t;
      eb = sub ? ~b : b;
      t = {1'b0, a} + {1'b0, eb} + {32'd0, sub};
      r.sum = t[31:0];
      r.carry = t[32];
      r.ovf = (a[31] == eb[31]) && (t[31] != a[31]);
      r.zero = t[31:0] == 32'd0;
      return r;
   endfunction

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input exp_t e);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL send_ready in_ready=%b want 1", in_ready); end
      in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
      t_acc = cyc;
      exp_q.push_back(e);
      @(posedge clk); #1 in_valid = 1'b0;
   endtask

   task automatic recv(input int lat);
      exp_t e;
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL recv_timeout out_valid=%b want 1", out_valid); return; end
      if (lat > 0) begin
         checks++;
         if (cyc - t_acc !== lat) begin errors++; $display("FAIL latency got %0d want %0d", cyc - t_acc, lat); end
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready got %b want 0", in_ready); end
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL scoreboard_empty got 0 entries want 1"); end
      else begin
         e = exp_q.pop_front();
         checks++;
         if (out_sum !== e.sum) begin errors++; $display("FAIL sum got %h want %h", out_sum, e.sum); end
         checks++;
         if ({out_carry, out_ovf, out_zero} !== {e.carry, e.ovf, e.zero})
            begin errors++; $display("FAIL flags c/o/z got %b%b%b want %b%b%b", out_carry, out_ovf, out_zero, e.carry, e.ovf, e.zero); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin errors++; $display("FAIL after_handshake in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy, out_carry, out_ovf, out_zero} !== 6'b100000)
         begin errors++; $display("FAIL reset_ctrl got %b want 100000", {in_ready, out_valid, busy, out_carry, out_ovf, out_zero}); end
      checks++;
      if (out_sum !== 32'd0) begin errors++; $display("FAIL reset_sum got %h want 0", out_sum); end
      checks++;
      if ({cla_a, cla_b, cla_cin} !== 17'd0) begin errors++; $display("FAIL reset_cla got %h want 0", {cla_a, cla_b, cla_cin}); end
   endtask

   task automatic test_add;
      send(32'hFFFF_FFFF, 32'h1, 1'b0, '{sum: 32'h0, carry: 1'b1, ovf: 1'b0, zero: 1'b1});
      recv(5);
      send(32'h7FFF_FFFF, 32'h1, 1'b0, '{sum: 32'h8000_0000, carry: 1'b0, ovf: 1'b1, zero: 1'b0});
      recv(5);
   endtask

   task automatic test_sub;
      send(32'd5, 32'd7, 1'b1, '{sum: 32'hFFFF_FFFE, carry: 1'b0, ovf: 1'b0, zero: 1'b0});
      recv(5);
      send(32'd7, 32'd5, 1'b1, '{sum: 32'h2, carry: 1'b1, ovf: 1'b0, zero: 1'b0});
      recv(5);
      send(32'h8000_0000, 32'h1, 1'b1, '{sum: 32'h7FFF_FFFF, carry: 1'b1, ovf: 1'b1, zero: 1'b0});
      recv(5);
   endtask

   task automatic test_backpressure;
      int n = 0;
      send(32'h1234_5678, 32'h1111_1111, 1'b0, '{sum: 32'h2345_6789, carry: 1'b0, ovf: 1'b0, zero: 1'b0});
      @(negedge clk);
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 32'h2345_6789)
            begin errors++; $display("FAIL hold[%0d] valid=%b ready=%b sum=%h want 1 0 23456789", i, out_valid, in_ready, out_sum); end
         in_valid = i[0];
         in_a = 32'hDEAD_0000 + i; in_b = 32'h0BAD_F00D; in_sub = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      recv(0);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_sum !== 32'h2345_6789)
         begin errors++; $display("FAIL idle_hold busy=%b valid=%b sum=%h want 0 0 23456789", busy, out_valid, out_sum); end
   endtask

   task automatic test_reset_midrun;
      send(32'hAABB_CCDD, 32'h1122_3344, 1'b0, model(32'hAABB_CCDD, 32'h1122_3344, 1'b0));
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || cla_a !== 8'hBB || cla_b !== 8'h22)
         begin errors++; $display("FAIL run_idx2 busy=%b cla_a=%h cla_b=%h want 1 bb 22", busy, cla_a, cla_b); end
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || {cla_a, cla_b, cla_cin} !== 17'd0)
         begin errors++; $display("FAIL midrun_reset ready=%b valid=%b busy=%b cla=%h want 1 0 0 0", in_ready, out_valid, busy, {cla_a, cla_b, cla_cin}); end
      send(32'h0000_00FF, 32'h0000_0001, 1'b0, '{sum: 32'h100, carry: 1'b0, ovf: 1'b0, zero: 1'b0});
      recv(5);
   endtask

   task automatic test_back_to_back;
      logic [31:0] a, b;
      logic s;
      for (int i = 0; i < 8; i++) begin
         a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
         if (i == 0) begin a = 32'h8000_0000; b = 32'h8000_0000; s = 1'b0; end
         if (i == 1) begin a = 32'h1357_9BDF; b = 32'h1357_9BDF; s = 1'b1; end
         send(a, b, s, model(a, b, s));
         recv(5);
      end
   endtask

   task automatic test_width8;
      int n = 0, t;
      @(negedge clk);
      w_in_a = 8'h80; w_in_b = 8'h80; w_in_sub = 1'b0; w_in_valid = 1'b1;
      t = cyc;
      @(posedge clk); #1 w_in_valid = 1'b0;
      @(negedge clk);
      while (!w_out_valid && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (w_out_valid !== 1'b1 || cyc - t !== 2)
         begin errors++; $display("FAIL w8_latency valid=%b got %0d want 2", w_out_valid, cyc - t); end
      checks++;
      if ({w_out_sum, w_out_carry, w_out_ovf, w_out_zero} !== {8'h00, 3'b111})
         begin errors++; $display("FAIL w8_result got %h c/o/z %b%b%b want 00 111", w_out_sum, w_out_carry, w_out_ovf, w_out_zero); end
      w_out_ready = 1'b1;
      @(posedge clk); #1 w_out_ready = 1'b0;
      checks++;
      if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1)
         begin errors++; $display("FAIL w8_handshake valid=%b ready=%b want 0 1", w_out_valid, w_in_ready); end
   endtask

   initial begin
      test_reset;
      test_add;
      test_sub;
      test_backpressure;
      test_reset_midrun;
      test_back_to_back;
      test_width8;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
